// File: rtl/wb_ssram_wbuf_pkg.sv
// Shared types for the wb_ssram_wbuf posted-write buffer: drain FSM states,
// FIFO entry layout and default depth.
package wb_ssram_wbuf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_GAP  = 2'd3
    } wbuf_state_t;

    // adr sits in the top bits so the FIFO can slice it out of raw storage
    typedef struct packed {
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } wbuf_entry_t;

    localparam int ENTRY_W   = $bits(wbuf_entry_t);
    localparam int DEPTH_DEF = 4;

endpackage

// File: rtl/wb_wbuf_fifo.sv
// Synchronous write FIFO for wb_ssram_wbuf. Exposes per-entry valid bits and
// word addresses so the top can detect read-after-write hazards.
module wb_wbuf_fifo
    import wb_ssram_wbuf_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  wbuf_entry_t            din,
    output wbuf_entry_t            head,
    output logic                   full,
    output logic                   empty,
    output logic [AW:0]            level,
    output logic [DEPTH-1:0]       vld,
    output logic [DEPTH-1:0][29:0] vadr
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wptr, rptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            vld   <= '0;
        end else begin
            // Clear before set: on a full push+pop both pointers hit the same slot
            if (pop) begin
                rptr      <= rptr + AW'(1);
                vld[rptr] <= 1'b0;
            end
            if (push) begin
                wptr      <= wptr + AW'(1);
                vld[wptr] <= 1'b1;
            end
            level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end

    assign head  = wbuf_entry_t'(mem[rptr]);
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);

    for (genvar i = 0; i < DEPTH; i++) begin : g_vadr
        assign vadr[i] = mem[i][ENTRY_W-1 -: 30];
    end

endmodule

// File: rtl/wb_ssram_wbuf.sv
// Posted-write buffer between a Wishbone classic master and wb_ssram_if.
// Optional WB_WBUF_RD_BYPASS_EN lets reads overtake queued non-matching writes.
module wb_ssram_wbuf
    import wb_ssram_wbuf_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   s_adr,
    input  logic [31:0]   s_din,
    output logic [31:0]   s_dout,
    input  logic          s_we,
    input  logic [3:0]    s_sel,
    input  logic          s_stb,
    input  logic          s_cyc,
    output logic          s_ack,
    output logic          s_err,
    output logic          s_rty,
    output logic [31:0]   m_adr,
    output logic [31:0]   m_dout,
    input  logic [31:0]   m_din,
    output logic          m_we,
    output logic [3:0]    m_sel,
    output logic          m_stb,
    output logic          m_cyc,
    input  logic          m_ack,
    input  logic          m_err,
    input  logic          m_rty,
    output logic [AW:0]   wbuf_level,
    output logic          wbuf_empty,
    output logic          wbuf_err
);

    wbuf_state_t            state, state_nx;
    wbuf_entry_t            head, push_ent;
    logic                   full, empty, push, pop, hit, rd_req, rd_go, rd_live, rd_done;
    logic [DEPTH-1:0]       vld, match;
    logic [DEPTH-1:0][29:0] vadr;
    logic [31:0]            rd_adr;
    logic [3:0]             rd_sel;

    assign s_rty    = 1'b0;
    assign pop      = (state == ST_WR) & (m_ack | m_err);
    assign push     = s_cyc & s_stb & s_we & !s_ack & (!full | pop);
    assign push_ent = '{adr: s_adr, sel: s_sel, dat: s_din};

    wb_wbuf_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_ent),
        .head  (head),
        .full  (full),
        .empty (empty),
        .level (wbuf_level),
        .vld   (vld),
        .vadr  (vadr)
    );

    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        assign match[i] = vld[i] & (vadr[i] == s_adr[31:2]);
    end
    assign hit    = |match;
    assign rd_req = s_cyc & s_stb & !s_we & !s_ack & !s_err;

`ifdef WB_WBUF_RD_BYPASS_EN
    assign rd_go = rd_req & !hit;
`else
    assign rd_go = rd_req & empty & !hit;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
`ifdef WB_WBUF_RD_BYPASS_EN
                // A hazard-free read jumps ahead of the queue
                if (rd_go)       state_nx = ST_RD;
                else if (!empty) state_nx = ST_WR;
`else
                if (!empty)      state_nx = ST_WR;
                else if (rd_go)  state_nx = ST_RD;
`endif
            end
            ST_WR, ST_RD: if (m_ack | m_err | m_rty) state_nx = ST_GAP;
            default:      state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        m_cyc  = 1'b0;
        m_stb  = 1'b0;
        m_we   = 1'b0;
        m_adr  = '0;
        m_sel  = '0;
        m_dout = '0;
        case (state)
            ST_WR: begin
                m_cyc  = 1'b1;
                m_stb  = 1'b1;
                m_we   = 1'b1;
                m_adr  = head.adr;
                m_sel  = head.sel;
                m_dout = head.dat;
            end
            ST_RD: begin
                m_cyc = 1'b1;
                m_stb = 1'b1;
                m_adr = rd_adr;
                m_sel = rd_sel;
            end
            default: ;
        endcase
    end

    assign wbuf_empty = empty & (state == ST_IDLE);
    // Master may abandon the cycle while the downstream read is in flight
    assign rd_done    = (state == ST_RD) & rd_live & s_cyc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_ack    <= 1'b0;
            s_err    <= 1'b0;
            s_dout   <= '0;
            rd_adr   <= '0;
            rd_sel   <= '0;
            rd_live  <= 1'b0;
            wbuf_err <= 1'b0;
        end else begin
            s_ack <= push | (rd_done & m_ack);
            s_err <= rd_done & !m_ack & m_err;
            if (rd_done & m_ack) s_dout <= m_din;
            if (state == ST_IDLE && state_nx == ST_RD) begin
                rd_adr  <= s_adr;
                rd_sel  <= s_sel;
                rd_live <= 1'b1;
            end else if (state == ST_RD && !s_cyc) begin
                rd_live <= 1'b0;
            end
            if (pop & !m_ack) wbuf_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_ssram_wbuf.sv
// Self-checking bench for wb_ssram_wbuf with a behavioural downstream SSRAM
// slave (programmable wait states and error/retry injection).
module tb_wb_ssram_wbuf;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic        clk = 1'b0, rst = 1'b0;
    logic [31:0] s_adr = '0, s_din = '0, s_dout, m_adr, m_dout, m_din;
    logic        s_we = 1'b0, s_stb = 1'b0, s_cyc = 1'b0, s_ack, s_err, s_rty;
    logic [3:0]  s_sel = '0, m_sel;
    logic        m_we, m_stb, m_cyc, m_ack, m_err, m_rty;
    logic [AW:0] wbuf_level;
    logic        wbuf_empty, wbuf_err;

    always #5 clk = ~clk;

    wb_ssram_wbuf #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .s_adr(s_adr), .s_din(s_din), .s_dout(s_dout), .s_we(s_we), .s_sel(s_sel),
        .s_stb(s_stb), .s_cyc(s_cyc), .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty),
        .m_adr(m_adr), .m_dout(m_dout), .m_din(m_din), .m_we(m_we), .m_sel(m_sel),
        .m_stb(m_stb), .m_cyc(m_cyc), .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty),
        .wbuf_level(wbuf_level), .wbuf_empty(wbuf_empty), .wbuf_err(wbuf_err)
    );

    // Downstream slave model
    logic [31:0] smem [0:255];
    int          slave_ws = 0, sl_txn = 0, err_txn = -1, rty_txn = -1, sl_cnt = 0;
    logic        sl_ack = 1'b0, sl_err = 1'b0, sl_rty = 1'b0;
    logic [68:0] obs_q [$];

    assign m_ack = sl_ack;
    assign m_err = sl_err;
    assign m_rty = sl_rty;
    assign m_din = smem[m_adr[9:2]];

    always @(posedge clk) begin
        sl_ack <= 1'b0;
        sl_err <= 1'b0;
        sl_rty <= 1'b0;
        if (m_cyc && m_stb && !(sl_ack || sl_err || sl_rty)) begin
            if (sl_cnt >= slave_ws) begin
                sl_cnt <= 0;
                sl_txn <= sl_txn + 1;
                if (sl_txn == err_txn)      sl_err <= 1'b1;
                else if (sl_txn == rty_txn) sl_rty <= 1'b1;
                else                        sl_ack <= 1'b1;
            end else begin
                sl_cnt <= sl_cnt + 1;
            end
        end else begin
            sl_cnt <= 0;
        end
        if (m_cyc && m_we && (sl_ack || sl_err)) obs_q.push_back({m_adr, m_sel, m_dout, sl_err});
        if (m_cyc && m_we && sl_ack)
            for (int b = 0; b < 4; b++)
                if (m_sel[b]) smem[m_adr[9:2]][8*b +: 8] <= m_dout[8*b +: 8];
    end

    // Bench-side reference state
    int          checks = 0, errors = 0;
    logic [31:0] ref_mem [0:255];
    logic [31:0] rdq [$];
    logic [68:0] exp_wq [$];

    task automatic idle_wait;
        while (s_ack || s_err) begin @(posedge clk); #1; end
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                            input logic err_exp, output int lat);
        idle_wait();
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_adr = adr; s_din = dat; s_sel = sel;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!s_ack && lat < 200);
        s_stb = 1'b0; s_we = 1'b0; s_cyc = 1'b0;
        checks++;
        if (s_ack !== 1'b1) begin
            errors++;
            $display("FAIL wr_ack adr=%h no ack after %0d cycles", adr, lat);
        end else begin
            exp_wq.push_back({adr, sel, dat, err_exp});
            for (int b = 0; b < 4; b++) if (sel[b]) ref_mem[adr[9:2]][8*b +: 8] = dat[8*b +: 8];
        end
    endtask

    task automatic wb_read(input logic [31:0] adr, input logic err_exp, output int lat);
        logic [31:0] exp_d, old;
        idle_wait();
        if (!err_exp) rdq.push_back(ref_mem[adr[9:2]]);
        old = s_dout;
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_adr = adr; s_sel = 4'hF;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!s_ack && !s_err && lat < 200);
        s_stb = 1'b0; s_cyc = 1'b0;
        checks++;
        if (err_exp) begin
            if (s_err !== 1'b1 || s_ack !== 1'b0 || s_dout !== old) begin
                errors++;
                $display("FAIL rd_err adr=%h got err=%b ack=%b dout=%h exp err=1 ack=0 dout=%h",
                         adr, s_err, s_ack, s_dout, old);
            end
        end else if (s_ack !== 1'b1) begin
            errors++;
            void'(rdq.pop_front());
            $display("FAIL rd_ack adr=%h got no ack (err=%b) after %0d cycles", adr, s_err, lat);
        end else begin
            exp_d = rdq.pop_front();
            if (s_dout !== exp_d) begin
                errors++;
                $display("FAIL rd_data adr=%h got=%h exp=%h", adr, s_dout, exp_d);
            end
        end
    endtask

    task automatic wait_drain;
        int n = 0;
        while (!wbuf_empty && n < 1000) begin @(posedge clk); #1; n++; end
        checks++;
        if (wbuf_empty !== 1'b1) begin
            errors++;
            $display("FAIL drain got wbuf_empty=%b level=%0d exp empty", wbuf_empty, wbuf_level);
        end
    endtask

    task automatic check_wstream(input string name);
        checks++;
        if (obs_q.size() != exp_wq.size()) begin
            errors++;
            $display("FAIL %s downstream writes got=%0d exp=%0d", name, obs_q.size(), exp_wq.size());
        end else begin
            for (int i = 0; i < exp_wq.size(); i++)
                if (obs_q[i] !== exp_wq[i]) begin
                    errors++;
                    $display("FAIL %s write[%0d] got=%h exp=%h", name, i, obs_q[i], exp_wq[i]);
                    break;
                end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({s_ack, s_err, s_rty, s_dout, m_cyc, m_stb, m_we, m_adr, m_sel, m_dout, wbuf_level, wbuf_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ack=%b err=%b cyc=%b adr=%h level=%0d werr=%b exp all 0",
                     s_ack, s_err, m_cyc, m_adr, wbuf_level, wbuf_err);
        end
        checks++;
        if (wbuf_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", wbuf_empty); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_wr_rd;
        int lat;
        wb_write(32'h0, 32'hDEADBEEF, 4'hF, 1'b0, lat);
        checks++;
        if (lat != 1) begin errors++; $display("FAIL wr_latency got=%0d exp=1", lat); end
        wb_read(32'h0, 1'b0, lat);
        wait_drain();
        wb_read(32'h0, 1'b0, lat);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL rd_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_burst;
        int lat;
        for (int i = 0; i < 4; i++) begin
            wb_write(32'(4*i), 32'hDEADBEE0 + 32'(i), 4'hF, 1'b0, lat);
            checks++;
            if (lat != 1) begin errors++; $display("FAIL burst_latency[%0d] got=%0d exp=1", i, lat); end
        end
        for (int i = 0; i < 4; i++) wb_read(32'(4*i), 1'b0, lat);
        wait_drain();
        check_wstream("burst");
    endtask

    task automatic test_stall;
        int lat;
        int lats [6];
        wait_drain();
        slave_ws = 8;
        for (int i = 0; i < 6; i++) begin
            wb_write(32'h20 + 32'(4*i), 32'hA0000000 + 32'(i), 4'hF, 1'b0, lat);
            lats[i] = lat;
            if (i == 3) begin
                checks++;
                if (wbuf_level !== 3'd4) begin errors++; $display("FAIL stall_level got=%0d exp=4", wbuf_level); end
            end
        end
        checks++;
        if (lats[0] != 1 || lats[1] != 1 || lats[2] != 1 || lats[3] != 1) begin
            errors++;
            $display("FAIL stall_fill_latency got=%0d,%0d,%0d,%0d exp=1,1,1,1", lats[0], lats[1], lats[2], lats[3]);
        end
        checks++;
        if (lats[4] <= 1) begin errors++; $display("FAIL stall_5th got latency=%0d exp >1", lats[4]); end
        for (int i = 0; i < 6; i++) wb_read(32'h20 + 32'(4*i), 1'b0, lat);
        wait_drain();
        slave_ws = 0;
        check_wstream("stall");
    endtask

    task automatic test_bytes;
        int lat;
        logic [31:0] dats [4];
        dats = '{32'h000000EF, 32'h0000BE00, 32'h00AD0000, 32'hDE000000};
        for (int i = 0; i < 4; i++) wb_write(32'h40, dats[i], 4'(1 << i), 1'b0, lat);
        wb_read(32'h40, 1'b0, lat);
        checks++;
        if (s_dout !== 32'hDEADBEEF) begin errors++; $display("FAIL bytes_merge got=%h exp=DEADBEEF", s_dout); end
        wait_drain();
        check_wstream("bytes");
    endtask

    task automatic test_err;
        int lat;
        wait_drain();
        err_txn = sl_txn + 1;
        wb_write(32'h80, 32'h11111111, 4'hF, 1'b0, lat);
        wb_write(32'h84, 32'h22222222, 4'hF, 1'b1, lat);
        wb_write(32'h88, 32'h33333333, 4'hF, 1'b0, lat);
        wait_drain();
        checks++;
        if (wbuf_err !== 1'b1) begin errors++; $display("FAIL wbuf_err_set got=%b exp=1", wbuf_err); end
        check_wstream("err");
        wb_read(32'h88, 1'b0, lat);
        wait_drain();
        err_txn = sl_txn;
        wb_read(32'h80, 1'b1, lat);
        err_txn = -1;
        wait_drain();
        checks++;
        if (wbuf_err !== 1'b1) begin errors++; $display("FAIL wbuf_err_sticky got=%b exp=1", wbuf_err); end
    endtask

    task automatic test_retry;
        int lat;
        wait_drain();
        rty_txn = sl_txn;
        wb_write(32'h90, 32'h5A5A5A5A, 4'hF, 1'b0, lat);
        wait_drain();
        rty_txn = sl_txn;
        wb_read(32'h90, 1'b0, lat);
        rty_txn = -1;
        wait_drain();
        check_wstream("retry");
    endtask

    task automatic test_abort;
        int seen = 0;
        wait_drain();
        slave_ws = 5;
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_adr = 32'h0; s_sel = 4'hF;
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (m_cyc !== 1'b1 || m_we !== 1'b0) begin
            errors++;
            $display("FAIL abort_rd_active got cyc=%b we=%b exp cyc=1 we=0", m_cyc, m_we);
        end
        s_cyc = 1'b0; s_stb = 1'b0;
        for (int i = 0; i < 15; i++) begin @(posedge clk); #1; if (s_ack || s_err) seen++; end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL abort_no_ack got %0d responses exp 0", seen); end
        wait_drain();
        slave_ws = 0;
    endtask

`ifdef WB_WBUF_RD_BYPASS_EN
    task automatic test_bypass;
        int lat;
        wait_drain();
        wb_write(32'h100, 32'h12345678, 4'hF, 1'b0, lat);
        wait_drain();
        slave_ws = 6;
        wb_write(32'h0, 32'h00000011, 4'hF, 1'b0, lat);
        wb_write(32'h4, 32'h00000022, 4'hF, 1'b0, lat);
        wb_write(32'h8, 32'h00000033, 4'hF, 1'b0, lat);
        wb_read(32'h100, 1'b0, lat);
        checks++;
        if (wbuf_level == 0) begin errors++; $display("FAIL bypass_overtake got level=0 exp >0"); end
        wb_read(32'h8, 1'b0, lat);
        wait_drain();
        slave_ws = 0;
        check_wstream("bypass");
    endtask
`endif

    task automatic test_mid_reset;
        int lat;
        wait_drain();
        slave_ws = 20;
        for (int i = 0; i < 3; i++) wb_write(32'h200 + 32'(4*i), 32'hC0DE0000 + 32'(i), 4'hF, 1'b0, lat);
        checks++;
        if (wbuf_level !== 3'd3 || m_cyc !== 1'b1 || m_we !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre got level=%0d cyc=%b we=%b exp 3,1,1", wbuf_level, m_cyc, m_we);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (m_cyc !== 1'b0 || m_stb !== 1'b0 || wbuf_level !== '0 || wbuf_empty !== 1'b1 || wbuf_err !== 1'b0) begin
            errors++;
            $display("FAIL midrst got cyc=%b stb=%b level=%0d empty=%b werr=%b exp 0,0,0,1,0",
                     m_cyc, m_stb, wbuf_level, wbuf_empty, wbuf_err);
        end
        repeat (3) void'(exp_wq.pop_back());
        @(posedge clk); #1;
        rst = 1'b1;
        slave_ws = 0;
        @(posedge clk); #1;
        wb_write(32'h0, 32'hCAFEF00D, 4'hF, 1'b0, lat);
        wb_read(32'h0, 1'b0, lat);
        wait_drain();
        check_wstream("midrst");
    endtask

    initial begin
        test_reset();
        test_wr_rd();
        test_burst();
        test_stall();
        test_bytes();
        test_err();
        test_retry();
        test_abort();
`ifdef WB_WBUF_RD_BYPASS_EN
        test_bypass();
`endif
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
